coherency_bus_ctrl: RTL and testbench

//  Bus-side (coherency_unit) end of the cache coherence interface for a dual-core MESI system.
//  - Arbitrates miss requests from two L1 caches.
//  - Snoops the other cache and sources the block cache-to-cache or from memory.
//  - Writes back dirty snooped data.
//  - Returns the block plus the requester's new MESI state, and drives state_transfer/snoop_complete to the snooped cache.

---
 rtl/coherency_bus_ctrl.sv | 178 +++++++++++++++++
 tb/tb_coherency_bus_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherency_bus_ctrl.sv
// Bus-side coherence controller for a dual-core MESI system: arbitrates L1 misses,
// snoops the peer cache, sources/writes back blocks. Optional macro: COHERENCE_STATS_EN.
module coherency_bus_ctrl #(
  parameter int unsigned BLOCK_SIZE = 2
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [1:0]                         bus_req,
  input  logic [1:0]                         bus_write,
  input  logic [1:0][31:0]                   bus_addr,
  output logic [1:0]                         snoop_req,
  output logic [31:0]                        addr,
  output logic [1:0]                         state_transfer,
  output logic [1:0]                         snoop_complete,
  input  logic [1:0]                         snoop_busy,
  input  logic [1:0]                         snoop_hit,
  input  logic [1:0]                         valid,
  input  logic [1:0]                         exclusive,
  input  logic [1:0]                         dirty,
  input  logic [1:0]                         dWEN,
  input  logic [1:0][32*BLOCK_SIZE-1:0]      requested_data,
  output logic [1:0]                         resp_valid,
  output logic [32*BLOCK_SIZE-1:0]           resp_data,
  output logic [1:0]                         resp_state,
  output logic                               mem_ren,
  output logic                               mem_wen,
  output logic [31:0]                        mem_addr,
  output logic [32*BLOCK_SIZE-1:0]           mem_wdata,
  input  logic [32*BLOCK_SIZE-1:0]           mem_rdata,
  input  logic                               mem_ready
`ifdef COHERENCE_STATS_EN
  ,
  output logic [31:0]                        to_i_transitions,
  output logic [31:0]                        to_s_transitions,
  output logic [31:0]                        to_e_transitions
`endif
);

  localparam int unsigned DW = 32 * BLOCK_SIZE;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    WB,
    MEMRD,
    DONE
  } state_t;

  state_t          state, state_nx;
  logic            ptr;
  logic            gnt_q;
  logic            wr_q;
  logic            hit_q;
  logic [31:0]     addr_q;
  logic [DW-1:0]   data_q;

  logic            oth;
  logic            gnt_nx;
  logic            snp_hit;
  logic            snp_dirty;
  logic            unused_exclusive;

  assign oth       = ~gnt_q;
  assign gnt_nx    = (bus_req == 2'b11) ? ptr : bus_req[1];
  assign snp_hit   = snoop_hit[oth] & valid[oth];
  assign snp_dirty = dirty[oth] | dWEN[oth];
  // exclusive does not alter any outcome: a hit always downgrades/invalidates the peer.
  assign unused_exclusive = ^exclusive;

  assign addr      = addr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign resp_data = data_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      gnt_q  <= 1'b0;
      wr_q   <= 1'b0;
      hit_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (|bus_req) begin
            gnt_q  <= gnt_nx;
            wr_q   <= bus_write[gnt_nx];
            addr_q <= bus_addr[gnt_nx];
          end
        end
        SNOOP: begin
          if (!snoop_busy[oth]) begin
            hit_q <= snp_hit;
            if (snp_hit) data_q <= requested_data[oth];
          end
        end
        MEMRD: begin
          if (mem_ready) data_q <= mem_rdata;
        end
        DONE: ptr <= oth;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx       = state;
    snoop_req      = '0;
    snoop_complete = '0;
    resp_valid     = '0;
    state_transfer = MESI_I;
    resp_state     = MESI_I;
    mem_ren        = 1'b0;
    mem_wen        = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus_req) state_nx = SNOOP;
      end
      SNOOP: begin
        snoop_req[oth] = 1'b1;
        if (!snoop_busy[oth]) begin
          if (!snp_hit)       state_nx = MEMRD;
          else if (snp_dirty) state_nx = WB;
          else                state_nx = DONE;
        end
      end
      WB: begin
        mem_wen = 1'b1;
        if (mem_ready) state_nx = DONE;
      end
      MEMRD: begin
        mem_ren = 1'b1;
        if (mem_ready) state_nx = DONE;
      end
      DONE: begin
        snoop_complete[oth] = 1'b1;
        resp_valid[gnt_q]   = 1'b1;
        if (wr_q) begin
          state_transfer = MESI_I;
          resp_state     = MESI_M;
        end else if (hit_q) begin
          state_transfer = MESI_S;
          resp_state     = MESI_S;
        end else begin
          state_transfer = MESI_I;
          resp_state     = MESI_E;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef COHERENCE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      to_i_transitions <= '0;
      to_s_transitions <= '0;
      to_e_transitions <= '0;
    end else if (state == DONE) begin
      if (wr_q && hit_q)        to_i_transitions <= to_i_transitions + 32'd1;
      else if (!wr_q && hit_q)  to_s_transitions <= to_s_transitions + 32'd1;
      else if (!wr_q)           to_e_transitions <= to_e_transitions + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coherency_bus_ctrl.sv
// Self-checking bench for coherency_bus_ctrl: directed table, reset/arbitration
// sequences and randomized transactions against a transaction-level model.
module tb_coherency_bus_ctrl;

  localparam logic [1:0] I_ST = 2'b00;
  localparam logic [1:0] S_ST = 2'b01;
  localparam logic [1:0] E_ST = 2'b10;
  localparam logic [1:0] M_ST = 2'b11;

  logic              CLK = 1'b0;
  logic              RST;
  logic [1:0]        bus_req, bus_write;
  logic [1:0][31:0]  bus_addr;
  logic [1:0]        snoop_req, state_transfer, snoop_complete;
  logic [31:0]       addr;
  logic [1:0]        snoop_busy, snoop_hit, valid, exclusive, dirty, dWEN;
  logic [1:0][63:0]  requested_data;
  logic [1:0]        resp_valid, resp_state;
  logic [63:0]       resp_data, mem_wdata, mem_rdata;
  logic              mem_ren, mem_wen, mem_ready;
  logic [31:0]       mem_addr;
`ifdef COHERENCE_STATS_EN
  logic [31:0]       to_i_transitions, to_s_transitions, to_e_transitions;
`endif

  coherency_bus_ctrl #(.BLOCK_SIZE(2)) dut (
    .CLK(CLK), .RST(RST),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .snoop_req(snoop_req), .addr(addr), .state_transfer(state_transfer),
    .snoop_complete(snoop_complete), .snoop_busy(snoop_busy), .snoop_hit(snoop_hit),
    .valid(valid), .exclusive(exclusive), .dirty(dirty), .dWEN(dWEN),
    .requested_data(requested_data), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_state(resp_state), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef COHERENCE_STATS_EN
    , .to_i_transitions(to_i_transitions), .to_s_transitions(to_s_transitions),
    .to_e_transitions(to_e_transitions)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        hit, vld, dty, dwen;
    int unsigned busy, mlat;
    logic [63:0] sdata, mdata;
  } snp_t;

  // mop: {wrote_back, read_memory}
  typedef struct {
    int unsigned lat;
    logic [1:0]  rs, st, mop;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic        g, wr;
    logic [31:0] a;
    snp_t        s;
    exp_t        e;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic        rr;
  int unsigned n_i, n_s, n_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  function automatic vec_t mkv(logic g, logic wr, logic [31:0] a, logic hit, logic vld,
                               logic dty, logic dwen, int unsigned busy, int unsigned mlat,
                               logic [63:0] sd, logic [63:0] md, int unsigned lat,
                               logic [1:0] rs, logic [1:0] st, logic [1:0] mop);
    vec_t v;
    v.g = g; v.wr = wr; v.a = a;
    v.s.hit = hit; v.s.vld = vld; v.s.dty = dty; v.s.dwen = dwen;
    v.s.busy = busy; v.s.mlat = mlat; v.s.sdata = sd; v.s.mdata = md;
    v.e.lat = lat; v.e.rs = rs; v.e.st = st; v.e.mop = mop; v.e.data = sd;
    v.e.data = md;
    if (mop != 2'b01) v.e.data = sd;
    return v;
  endfunction

  // Transaction-level outcome of one miss given the peer's snoop answer.
  function automatic exp_t ref_model(snp_t s, logic wr);
    exp_t e;
    bit   hit   = s.hit && s.vld;
    bit   dty   = s.dty || s.dwen;
    e.mop  = !hit ? 2'b01 : (dty ? 2'b10 : 2'b00);
    e.lat  = 3 + s.busy + ((e.mop != 2'b00) ? s.mlat : 0);
    e.data = hit ? s.sdata : s.mdata;
    e.rs   = wr ? M_ST : (hit ? S_ST : E_ST);
    e.st   = (!wr && hit) ? S_ST : I_ST;
    return e;
  endfunction

  function automatic snp_t rand_snp();
    snp_t s;
    s.hit  = 1'($urandom);
    s.vld  = ($urandom_range(0, 3) != 0);
    s.dty  = 1'($urandom);
    s.dwen = ($urandom_range(0, 3) == 0);
    s.busy = $urandom_range(0, 5);
    s.mlat = $urandom_range(1, 4);
    s.sdata = {$urandom, $urandom};
    s.mdata = {$urandom, $urandom};
    return s;
  endfunction

  task automatic check_reset(input string nm);
    chk({nm, "_snoop_req"}, 64'(snoop_req), 64'(0));
    chk({nm, "_addr"}, 64'(addr), 64'(0));
    chk({nm, "_st"}, 64'(state_transfer), 64'(I_ST));
    chk({nm, "_snoop_complete"}, 64'(snoop_complete), 64'(0));
    chk({nm, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({nm, "_resp_data"}, resp_data, 64'(0));
    chk({nm, "_resp_state"}, 64'(resp_state), 64'(0));
    chk({nm, "_mem_strobes"}, 64'({mem_ren, mem_wen}), 64'(0));
    chk({nm, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({nm, "_mem_wdata"}, mem_wdata, 64'(0));
`ifdef COHERENCE_STATS_EN
    chk({nm, "_stats"}, 64'(to_i_transitions | to_s_transitions | to_e_transitions), 64'(0));
`endif
  endtask

  // Entered just after a clock edge with the DUT idle and bus_req already driven.
  task automatic run_txn(input string nm, input logic g, input snp_t s, input exp_t e,
                         input bit drop);
    logic        o, wr;
    int unsigned cyc, busy_left, mcnt, snp_cyc;
    bit          seen, did_rd, did_wr;
    o = ~g; wr = bus_write[g];
    cyc = 0; busy_left = s.busy; mcnt = 0; snp_cyc = 0;
    seen = 0; did_rd = 0; did_wr = 0;
    snoop_hit = 2'($urandom); valid = 2'($urandom); dirty = 2'($urandom);
    dWEN = 2'($urandom); exclusive = 2'($urandom);
    requested_data[g] = {$urandom, $urandom};
    snoop_hit[o] = s.hit; valid[o] = s.vld; dirty[o] = s.dty; dWEN[o] = s.dwen;
    requested_data[o] = s.sdata;
    while (!seen && cyc < 200) begin
      @(posedge CLK); #1;
      cyc++;
      if (drop && cyc == 2) bus_req[g] = 1'b0;
      if (snoop_req != 2'b00) begin
        chk({nm, "_snpsel"}, 64'(snoop_req), 64'(2'b01 << o));
        chk({nm, "_snpaddr"}, 64'(addr), 64'(bus_addr[g]));
        snp_cyc++;
        snoop_busy[o] = (busy_left > 0);
        snoop_busy[g] = 1'($urandom);
        if (busy_left > 0) busy_left--;
      end else begin
        snoop_busy = 2'($urandom);
      end
      if (mem_ren || mem_wen) begin
        mcnt++;
        chk({nm, "_maddr"}, 64'(mem_addr), 64'(bus_addr[g]));
        if (mem_wen) begin
          did_wr = 1;
          chk({nm, "_mwdata"}, mem_wdata, s.sdata);
        end
        if (mem_ren) did_rd = 1;
        mem_ready = (mcnt == s.mlat);
        mem_rdata = mem_ready ? s.mdata : {$urandom, $urandom};
      end else begin
        mem_ready = 1'($urandom);
        mem_rdata = {$urandom, $urandom};
      end
      if (resp_valid != 2'b00) begin
        seen = 1;
        chk({nm, "_grant"}, 64'(resp_valid), 64'(2'b01 << g));
        chk({nm, "_complete"}, 64'(snoop_complete), 64'(2'b01 << o));
        chk({nm, "_data"}, resp_data, e.data);
        chk({nm, "_rstate"}, 64'(resp_state), 64'(e.rs));
        chk({nm, "_xfer"}, 64'(state_transfer), 64'(e.st));
        chk({nm, "_latency"}, 64'(cyc + 1), 64'(e.lat));
        chk({nm, "_snpcycles"}, 64'(snp_cyc), 64'(s.busy + 1));
        chk({nm, "_memops"}, 64'({did_wr, did_rd}), 64'(e.mop));
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: no resp_valid after %0d cycles, want one", nm, cyc);
    end else begin
      bus_req[g] = 1'b0; mem_ready = 1'b0; snoop_busy = 2'b00;
      @(posedge CLK); #1;
      chk({nm, "_pulse"}, 64'({resp_valid, snoop_complete}), 64'(0));
      rr = o;
      if (wr && s.hit && s.vld)       n_i++;
      else if (!wr && s.hit && s.vld) n_s++;
      else if (!wr)                   n_e++;
    end
  endtask

  task automatic go(input string nm, input snp_t s, input bit drop);
    logic g;
    g = (bus_req == 2'b11) ? rr : bus_req[1];
    run_txn(nm, g, s, ref_model(s, bus_write[g]), drop);
  endtask

  task automatic abort_test(input string nm, input bit wb);
    int unsigned cyc;
    cyc = 0;
    bus_write[0] = 1'b0; bus_addr[0] = 32'h500; bus_req = 2'b01;
    snoop_hit[1] = wb; valid[1] = wb; dirty[1] = wb; dWEN[1] = 1'b0;
    requested_data[1] = 64'h5151; snoop_busy = 2'b00; mem_ready = 1'b0;
    do begin
      @(posedge CLK); #1;
      cyc++;
    end while (!(wb ? mem_wen : mem_ren) && cyc < 20);
    chk({nm, "_strobe"}, 64'(wb ? mem_wen : mem_ren), 64'(1));
    RST = 1'b1;
    @(posedge CLK); #1;
    check_reset({nm, "_rst"});
    RST = 1'b0; bus_req = 2'b00;
    rr = 1'b0; n_i = 0; n_s = 0; n_e = 0;
    repeat (4) begin
      @(posedge CLK); #1;
      chk({nm, "_quiet"}, 64'({resp_valid, snoop_complete}), 64'(0));
    end
  endtask

  vec_t tbl[8];
  snp_t sv;

  initial begin
    tbl[0] = mkv(0, 0, 32'h100, 0, 0, 0, 0, 0, 2, 64'h5555, 64'hAAAA_BBBB_CCCC_DDDD, 5, E_ST, I_ST, 2'b01);
    tbl[1] = mkv(1, 0, 32'h200, 1, 1, 0, 0, 0, 1, 64'h1234, 64'h0BAD, 3, S_ST, S_ST, 2'b00);
    tbl[2] = mkv(0, 1, 32'h300, 1, 1, 1, 0, 0, 1, 64'hDEAD, 64'h0BAD, 4, M_ST, I_ST, 2'b10);
    tbl[3] = mkv(1, 0, 32'h340, 1, 0, 1, 1, 0, 3, 64'h0BAD, 64'h77, 6, E_ST, I_ST, 2'b01);
    tbl[4] = mkv(0, 0, 32'h380, 1, 1, 0, 1, 2, 2, 64'hCAFE, 64'h0, 7, S_ST, S_ST, 2'b10);
    tbl[5] = mkv(1, 1, 32'h3C0, 0, 1, 0, 0, 1, 1, 64'h0, 64'h99, 5, M_ST, I_ST, 2'b01);
    tbl[6] = mkv(0, 1, 32'h400, 1, 1, 0, 0, 0, 1, 64'h42, 64'h0, 3, M_ST, I_ST, 2'b00);
    tbl[7] = mkv(1, 1, 32'h440, 0, 0, 1, 1, 3, 4, 64'hF00D, 64'h1111, 10, M_ST, I_ST, 2'b01);

    RST = 1'b1; bus_req = '0; bus_write = '0; bus_addr = '0; snoop_busy = '0;
    snoop_hit = '0; valid = '0; exclusive = '0; dirty = '0; dWEN = '0;
    requested_data = '0; mem_rdata = '0; mem_ready = 1'b0;
    rr = 1'b0; n_i = 0; n_s = 0; n_e = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset("reset");
    RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      bus_req = 2'b01 << tbl[i].g;
      bus_write[tbl[i].g] = tbl[i].wr;
      bus_addr[tbl[i].g]  = tbl[i].a;
      run_txn($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].e, 1'b0);
`ifdef COHERENCE_STATS_EN
      if (i == 2) begin
        chk("stats_to_e", 64'(to_e_transitions), 64'(1));
        chk("stats_to_s", 64'(to_s_transitions), 64'(1));
        chk("stats_to_i", 64'(to_i_transitions), 64'(1));
      end
`endif
    end

    abort_test("abort_memrd", 1'b0);
    bus_req = 2'b10; bus_write[1] = 1'b0; bus_addr[1] = 32'h600;
    go("post_rst", rand_snp(), 1'b0);
    abort_test("abort_wb", 1'b1);

    // Both caches request continuously; cache 1 stalls its first snoop for 4 cycles.
    bus_write = 2'b00; bus_addr[0] = 32'h700; bus_addr[1] = 32'h780; bus_req = 2'b11;
    sv = mkv(0, 0, 0, 1, 1, 0, 0, 4, 1, 64'h4444, 64'h0, 0, 0, 0, 0).s;
    run_txn("rr_a", 1'b0, sv, ref_model(sv, 1'b0), 1'b0);
    bus_req[0] = 1'b1; bus_addr[0] = 32'h7C0;
    sv = rand_snp();
    run_txn("rr_b", 1'b1, sv, ref_model(sv, 1'b0), 1'b0);
    bus_req[1] = 1'b1; bus_addr[1] = 32'h800;
    sv = rand_snp();
    run_txn("rr_c", 1'b0, sv, ref_model(sv, 1'b0), 1'b0);
    sv = rand_snp();
    run_txn("rr_d", 1'b1, sv, ref_model(sv, 1'b0), 1'b0);

    for (int n = 0; n < 60; n++) begin
      int unsigned pat;
      pat = $urandom_range(1, 3);
      for (int c = 0; c < 2; c++) begin
        bus_write[c] = 1'($urandom);
        bus_addr[c]  = {$urandom} & 32'hFFFF_FFF8;
      end
      bus_req = 2'(pat);
      if (pat == 3) begin
        go($sformatf("rnd%0d_a", n), rand_snp(), 1'b0);
        go($sformatf("rnd%0d_b", n), rand_snp(), 1'b0);
      end else begin
        go($sformatf("rnd%0d", n), rand_snp(), 1'($urandom));
      end
    end

`ifdef COHERENCE_STATS_EN
    chk("stats_final_i", 64'(to_i_transitions), 64'(n_i));
    chk("stats_final_s", 64'(to_s_transitions), 64'(n_s));
    chk("stats_final_e", 64'(to_e_transitions), 64'(n_e));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
